// File: rtl/upcoin_pkg.sv
// -----------------------------------------------------------------------------
// upcoin_pkg
// Shared types and constants for the uPcoin SPI block loader.
//   state_t       : loader state machine encoding
//   *_DEF         : default block / digest widths of the hash engine
//   fifo_entry_t  : one buffered message block plus its end-of-message tag,
//                   sized for the default block width
// -----------------------------------------------------------------------------
package upcoin_pkg;

    localparam int BLOCK_BITS_DEF  = 512;
    localparam int DIGEST_BITS_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD        = 2'd1,
        ST_WAIT_DIGEST = 2'd2,
        ST_READOUT     = 2'd3
    } state_t;

    typedef struct packed {
        logic                      last;
        logic [BLOCK_BITS_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/spi_block_loader_if.sv
// -----------------------------------------------------------------------------
// spi_block_loader_if
// Core-side bus between the SPI block loader and the hash core.
//   blk_valid/blk_ready : block handshake, pop on valid && ready
//   blk_data/blk_last   : FIFO head block and its end-of-message tag
//   digest_valid/digest : one-cycle digest strobe and value from the core
// Modports: master = loader side, slave = hash core side.
// -----------------------------------------------------------------------------
interface spi_block_loader_if #(
    parameter int BLOCK_BITS  = upcoin_pkg::BLOCK_BITS_DEF,
    parameter int DIGEST_BITS = upcoin_pkg::DIGEST_BITS_DEF
);
    logic                   blk_valid;
    logic                   blk_ready;
    logic [BLOCK_BITS-1:0]  blk_data;
    logic                   blk_last;
    logic                   digest_valid;
    logic [DIGEST_BITS-1:0] digest;

    modport master (
        output blk_valid, blk_data, blk_last,
        input  blk_ready, digest_valid, digest
    );

    modport slave (
        input  blk_valid, blk_data, blk_last,
        output blk_ready, digest_valid, digest
    );
endinterface

// File: rtl/block_fifo.sv
// -----------------------------------------------------------------------------
// block_fifo
// Synchronous FIFO with a registered head output (first-word fall-through).
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear, empties the FIFO
//   push/push_data : write request; ignored when full unless a pop occurs
//                    in the same cycle
//   pop        : read request; ignored when empty
//   head_data  : registered head entry, stable while no pop occurs
//   valid      : FIFO not empty
//   full       : FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module block_fifo #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] head_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             valid_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop && valid_r;
    assign do_push_s = push && (!full_s || do_pop_s);

    assign head_data = head_r;
    assign valid     = valid_r;
    assign full      = full_s;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and the registered head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            head_r   <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else if (clr) begin
            head_r   <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            // The head register tracks mem[rd_ptr] one cycle ahead so the
            // output never passes through the read mux.
            if (do_pop_s) begin
                if (count_r > CNT_W'(1'b1)) begin
                    head_r <= mem_r[ptr_inc(rd_ptr_r)];
                end else if (do_push_s) begin
                    head_r <= push_data;
                end
            end else if ((count_r == '0) && do_push_s) begin
                head_r <= push_data;
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
        end
    end

endmodule

// File: rtl/spi_block_loader.sv
// -----------------------------------------------------------------------------
// spi_block_loader
// SPI front end for the uPcoin hash engine. Deserialises message blocks from
// the SPI master, buffers them in a block FIFO for the hash core (last block
// tagged), captures the core's digest and shifts it back out on sdo.
//   clk, reset         : system clock, asynchronous active-high reset
//   sck, sdi, sdo      : SPI clock / data in / data out, MSB first
//   message_load       : high for the whole message transfer
//   block_load         : bits are accepted only while high
//   input_ready        : loader can accept further bits
//   core               : block handshake and digest input (master modport)
//   done               : digest ready for readout
//   overrun, partial   : sticky error flags (bit dropped / message ended
//                        mid-block)
// BLOCK_BITS must be at least 3; SYNC_STAGES at least 2.
// -----------------------------------------------------------------------------
module spi_block_loader
    import upcoin_pkg::*;
#(
    parameter int BLOCK_BITS  = BLOCK_BITS_DEF,
    parameter int DIGEST_BITS = DIGEST_BITS_DEF,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    output logic               sdo,
    input  logic               message_load,
    input  logic               block_load,
    output logic               input_ready,
    spi_block_loader_if.master core,
    output logic               done,
    output logic               overrun,
    output logic               partial
);
    localparam int CNT_W = $clog2(BLOCK_BITS);
    localparam int RD_W  = (DIGEST_BITS > 1) ? $clog2(DIGEST_BITS) : 1;

    // Synchronisers and edge history
    logic [SYNC_STAGES-1:0] sck_sync_r, sdi_sync_r, ml_sync_r, bl_sync_r;
    logic sck_prev_r, ml_prev_r;
    logic sck_s, sdi_s, ml_s, bl_s;
    logic sck_rise_s, sck_fall_s, ml_rise_s;

    // Control
    state_t state_r, state_nxt_s;
    logic   in_load_s, input_ready_s, bit_s, accept_s, drop_s;
    logic   first_bit_s, blk_done_s, end_s, start_s, abort_s;
    logic   push_next_s, push_end_s, push_s, pop_s, fifo_can_push_s;
    logic   dig_latch_s, rd_last_s;

    // Datapath
    logic [BLOCK_BITS-2:0]  shift_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [BLOCK_BITS-1:0]  stg_data_r;
    logic                   stg_full_r;
    logic [DIGEST_BITS-1:0] dig_r;
    logic [RD_W-1:0]        rd_cnt_r;
    logic                   done_r, overrun_r, partial_r;

    // FIFO
    logic [BLOCK_BITS:0]    fifo_head_s;
    logic                   fifo_valid_s, fifo_full_s;

    assign sck_s = sck_sync_r[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_r[SYNC_STAGES-1];
    assign ml_s  = ml_sync_r[SYNC_STAGES-1];
    assign bl_s  = bl_sync_r[SYNC_STAGES-1];

    assign sck_rise_s = sck_s && !sck_prev_r;
    assign sck_fall_s = !sck_s && sck_prev_r;
    assign ml_rise_s  = ml_s && !ml_prev_r;

    assign in_load_s     = (state_r == ST_LOAD);
    assign input_ready_s = in_load_s && !(stg_full_r && fifo_full_s);
    assign bit_s         = sck_rise_s && bl_s;
    assign accept_s      = bit_s && input_ready_s && ml_s;
    assign drop_s        = bit_s && !input_ready_s;
    assign first_bit_s   = accept_s && (cnt_r == '0);
    assign blk_done_s    = accept_s && (cnt_r == CNT_W'(BLOCK_BITS - 1));
    assign end_s         = in_load_s && !ml_s;

    assign pop_s           = fifo_valid_s && core.blk_ready;
    assign fifo_can_push_s = !fifo_full_s || pop_s;
    // A completed block waits in staging until we know whether it is the last:
    // the next block's first bit says "no", the end of the message says "yes".
    assign push_next_s = first_bit_s && stg_full_r;
    assign push_end_s  = end_s && stg_full_r && fifo_can_push_s;
    assign push_s      = push_next_s || push_end_s;

    assign start_s     = ml_rise_s && (state_r != ST_LOAD);
    assign abort_s     = ml_rise_s && ((state_r == ST_WAIT_DIGEST) || (state_r == ST_READOUT));
    assign dig_latch_s = (state_r == ST_WAIT_DIGEST) && core.digest_valid && !ml_rise_s;
    assign rd_last_s   = (rd_cnt_r == RD_W'(DIGEST_BITS - 1));

    assign sdo            = dig_r[DIGEST_BITS-1];
    assign input_ready    = input_ready_s;
    assign done           = done_r;
    assign overrun        = overrun_r;
    assign partial        = partial_r;
    assign core.blk_valid = fifo_valid_s;
    assign core.blk_data  = fifo_head_s[BLOCK_BITS-1:0];
    assign core.blk_last  = fifo_head_s[BLOCK_BITS];

    // Bring the SPI pins into the clk domain and keep one cycle of history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_r <= '0;
            sdi_sync_r <= '0;
            ml_sync_r  <= '0;
            bl_sync_r  <= '0;
            sck_prev_r <= 1'b0;
            ml_prev_r  <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
            ml_sync_r  <= {ml_sync_r[SYNC_STAGES-2:0], message_load};
            bl_sync_r  <= {bl_sync_r[SYNC_STAGES-2:0], block_load};
            sck_prev_r <= sck_s;
            ml_prev_r  <= ml_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ml_rise_s) state_nxt_s = ST_LOAD;
                else           state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                // Leave only once staging has been handed to the FIFO.
                if (end_s && (!stg_full_r || fifo_can_push_s)) state_nxt_s = ST_WAIT_DIGEST;
                else                                           state_nxt_s = ST_LOAD;
            end
            ST_WAIT_DIGEST: begin
                if (ml_rise_s)              state_nxt_s = ST_LOAD;
                else if (core.digest_valid) state_nxt_s = ST_READOUT;
                else                        state_nxt_s = ST_WAIT_DIGEST;
            end
            ST_READOUT: begin
                if (ml_rise_s)                    state_nxt_s = ST_LOAD;
                else if (sck_fall_s && rd_last_s) state_nxt_s = ST_IDLE;
                else                              state_nxt_s = ST_READOUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bit capture, staging and the sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r    <= '0;
            cnt_r      <= '0;
            stg_data_r <= '0;
            stg_full_r <= 1'b0;
            overrun_r  <= 1'b0;
            partial_r  <= 1'b0;
        end else begin
            if (start_s) begin
                cnt_r      <= '0;
                stg_full_r <= 1'b0;
            end else begin
                if (push_s) begin
                    stg_full_r <= 1'b0;
                end
                if (blk_done_s) begin
                    stg_full_r <= 1'b1;
                    stg_data_r <= {shift_r, sdi_s};
                end
                if (accept_s) begin
                    shift_r <= {shift_r[BLOCK_BITS-3:0], sdi_s};
                    cnt_r   <= blk_done_s ? '0 : (cnt_r + CNT_W'(1'b1));
                end else if (end_s && (cnt_r != '0)) begin
                    // Incomplete block at end of message is discarded.
                    cnt_r <= '0;
                end
            end
            if (start_s) begin
                overrun_r <= 1'b0;
                partial_r <= 1'b0;
            end else begin
                if (drop_s) overrun_r <= 1'b1;
                if (end_s && (cnt_r != '0)) partial_r <= 1'b1;
            end
        end
    end

    // Digest latch and MSB-first readout on falling sck edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_r    <= '0;
            rd_cnt_r <= '0;
            done_r   <= 1'b0;
        end else if (abort_s) begin
            dig_r    <= '0;
            rd_cnt_r <= '0;
            done_r   <= 1'b0;
        end else if (dig_latch_s) begin
            dig_r    <= core.digest;
            rd_cnt_r <= '0;
            done_r   <= 1'b1;
        end else if ((state_r == ST_READOUT) && sck_fall_s) begin
            if (rd_last_s) begin
                dig_r    <= '0;
                rd_cnt_r <= '0;
                done_r   <= 1'b0;
            end else begin
                dig_r    <= {dig_r[DIGEST_BITS-2:0], 1'b0};
                rd_cnt_r <= rd_cnt_r + RD_W'(1'b1);
            end
        end
    end

    block_fifo #(
        .WIDTH (BLOCK_BITS + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .clr       (abort_s),
        .push      (push_s),
        .push_data ({push_end_s, stg_data_r}),
        .pop       (core.blk_ready),
        .head_data (fifo_head_s),
        .valid     (fifo_valid_s),
        .full      (fifo_full_s)
    );

endmodule
